// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard bubble stage: control bundle layout,
// default NOP bundle and the stall FSM state type.
package hazard_pkg;

    localparam int unsigned CTRL_W = 11;

    // Control bundle field positions, LSB upwards
    localparam int unsigned ALUOP_LSB     = 0;
    localparam int unsigned ALUOP_W       = 2;
    localparam int unsigned REGWRITE_LSB  = 2;
    localparam int unsigned REGWRITE_W    = 2;
    localparam int unsigned ALUSRC2_BIT   = 4;
    localparam int unsigned ALUSRC1_BIT   = 5;
    localparam int unsigned MEMTOREG_BIT  = 6;
    localparam int unsigned MEMREAD_BIT   = 7;
    localparam int unsigned MEMWRITE_BIT  = 8;
    localparam int unsigned UPPERBYTE_BIT = 9;
    localparam int unsigned STRBYTE_BIT   = 10;

    localparam logic [CTRL_W-1:0] NOP_VALUE = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_bubble_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// Registered ID/EX control stage: inserts NOP bubbles on load-use stalls,
// squashes on taken-branch flush, and counts inserted bubbles.
module hazard_bubble_ctrl #(
    parameter int unsigned              CTRL_W        = hazard_pkg::CTRL_W,
    parameter int unsigned              BUBBLE_CYCLES = 1,
    parameter logic [CTRL_W-1:0]        NOP_VALUE     = CTRL_W'(hazard_pkg::NOP_VALUE),
    parameter int unsigned              CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              stall_req,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              bubble_active,
    output logic              stalled,
    output logic [CNT_W-1:0]  bubble_count
);

    import hazard_pkg::*;

    localparam int unsigned RW = $clog2(BUBBLE_CYCLES + 1);

    state_e            state_q, state_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              bub_q, bub_d;
    logic              bubble_inc;
    logic              hold;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        ctrl_d     = ctrl_in;
        bub_d      = 1'b0;
        bubble_inc = 1'b0;
        hold       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    ctrl_d     = NOP_VALUE;
                    bub_d      = 1'b1;
                    bubble_inc = 1'b1;
                end else if (stall_req) begin
                    ctrl_d     = NOP_VALUE;
                    bub_d      = 1'b1;
                    bubble_inc = 1'b1;
                    hold       = 1'b1;
                    if (BUBBLE_CYCLES > 1) begin
                        state_d = STALL;
                        rem_d   = RW'(BUBBLE_CYCLES - 1);
                    end
                end
            end
            STALL: begin
                ctrl_d     = NOP_VALUE;
                bub_d      = 1'b1;
                bubble_inc = 1'b1;
                // Flush abandons the remaining bubbles; stall_req is ignored here
                if (flush) begin
                    rem_d   = '0;
                    state_d = RUN;
                end else begin
                    hold  = 1'b1;
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            rem_q   <= '0;
            ctrl_q  <= NOP_VALUE;
            bub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ctrl_q  <= ctrl_d;
            bub_q   <= bub_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    // Reset forces the front end to keep fetching regardless of stall inputs
    assign pc_write      = rst | ~hold;
    assign ifid_write    = rst | ~hold;
    assign ctrl_out      = ctrl_q;
    assign bubble_active = bub_q;
    assign stalled       = (state_q == STALL);

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Self-checking bench: three configurations share one stimulus stream and are
// compared against a cycle-level bubble-debt reference model.
module tb_hazard_bubble_ctrl;

    logic        clk;
    logic        rst;
    logic [10:0] ctrl_in;
    logic        stall_req;
    logic        flush;

    logic [10:0] co [3];
    logic        pw [3];
    logic        iw [3];
    logic        ba [3];
    logic        st [3];
    logic [31:0] bc [3];
    logic [15:0] bc0, bc1;
    logic [1:0]  bc2;

    assign bc[0] = {16'b0, bc0};
    assign bc[1] = {16'b0, bc1};
    assign bc[2] = {30'b0, bc2};

    hazard_bubble_ctrl #(.CTRL_W(11), .BUBBLE_CYCLES(1), .NOP_VALUE(11'h000), .CNT_W(16)) u_b1 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .stall_req(stall_req), .flush(flush),
        .ctrl_out(co[0]), .pc_write(pw[0]), .ifid_write(iw[0]), .bubble_active(ba[0]),
        .stalled(st[0]), .bubble_count(bc0));

    hazard_bubble_ctrl #(.CTRL_W(11), .BUBBLE_CYCLES(3), .NOP_VALUE(11'h000), .CNT_W(16)) u_b3 (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .stall_req(stall_req), .flush(flush),
        .ctrl_out(co[1]), .pc_write(pw[1]), .ifid_write(iw[1]), .bubble_active(ba[1]),
        .stalled(st[1]), .bubble_count(bc1));

    hazard_bubble_ctrl #(.CTRL_W(11), .BUBBLE_CYCLES(2), .NOP_VALUE(11'h000), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .stall_req(stall_req), .flush(flush),
        .ctrl_out(co[2]), .pc_write(pw[2]), .ifid_write(iw[2]), .bubble_active(ba[2]),
        .stalled(st[2]), .bubble_count(bc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: bubble debt owed per instance, plus expected outputs
    int          bcyc [3] = '{1, 3, 2};
    int          cmax [3] = '{65535, 65535, 3};
    int          m_pend [3];
    int          m_cnt [3];
    logic [10:0] m_out [3];
    logic        m_bub [3];
    logic        pwe [3];
    logic        pw_s [3];
    logic        iw_s [3];

    task automatic tick(input logic r, input logic s, input logic f, input logic [10:0] c);
        rst = r; stall_req = s; flush = f; ctrl_in = c;
        #3;
        for (int i = 0; i < 3; i++) begin
            pw_s[i] = pw[i];
            iw_s[i] = iw[i];
            pwe[i]  = r | f | !(s || (m_pend[i] > 0));
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_out[i] = 11'h000; m_bub[i] = 1'b0; m_pend[i] = 0; m_cnt[i] = 0;
            end else if (f || s || (m_pend[i] > 0)) begin
                m_out[i] = 11'h000; m_bub[i] = 1'b1;
                m_cnt[i] = (m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : cmax[i];
                if (f)                m_pend[i] = 0;
                else if (m_pend[i] > 0) m_pend[i] = m_pend[i] - 1;
                else                  m_pend[i] = bcyc[i] - 1;
            end else begin
                m_out[i] = c; m_bub[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 11'h000);
        tick(1'b1, 1'b0, 1'b0, 11'h000);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, (k == 0), 1'b0, 11'h7F6);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (co[i] !== 11'h000 || bc[i] !== 32'd0 || ba[i] !== 1'b0 || st[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset inst%0d: ctrl_out=%h cnt=%0d bub=%b stalled=%b, want 000/0/0/0",
                             i, co[i], bc[i], ba[i], st[i]);
                end
                n_cmp++;
                if (pw_s[i] !== 1'b1 || iw_s[i] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset_pcwrite inst%0d: pc_write=%b ifid_write=%b, want 1/1", i, pw_s[i], iw_s[i]);
                end
            end
        end
    endtask

    task automatic test_passthrough();
        tick(1'b0, 1'b0, 1'b0, 11'h7F6);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (co[i] !== 11'h7F6 || pw_s[i] !== 1'b1 || ba[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL passthrough inst%0d: ctrl_out=%h pc_write=%b bub=%b, want 7f6/1/0",
                         i, co[i], pw_s[i], ba[i]);
            end
        end
    endtask

    task automatic test_single_bubble();
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 11'h7F6);
        n_cmp++;
        if (pw_s[0] !== 1'b0 || iw_s[0] !== 1'b0 || co[0] !== 11'h000 || ba[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_bubble: pc_write=%b ifid_write=%b ctrl_out=%h bub=%b, want 0/0/000/1",
                     pw_s[0], iw_s[0], co[0], ba[0]);
        end
        tick(1'b0, 1'b0, 1'b0, 11'h7F6);
        n_cmp++;
        if (co[0] !== 11'h7F6 || ba[0] !== 1'b0 || bc[0] !== 32'd1 || pw_s[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_resume: ctrl_out=%h bub=%b cnt=%0d pc_write=%b, want 7f6/0/1/1",
                     co[0], ba[0], bc[0], pw_s[0]);
        end
    endtask

    task automatic test_multi_bubble();
        int lows = 0, nops = 0, sts = 0;
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 11'h7F6);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick(1'b0, 1'b0, 1'b0, 11'h7F6);
            if (pw_s[1] === 1'b0) lows++;
            if (co[1] === 11'h000) nops++;
            if (st[1] === 1'b1) sts++;
        end
        n_cmp++;
        if (lows != 3 || nops != 3 || sts != 2 || bc[1] !== 32'd3) begin
            n_bad++;
            $display("FAIL multi_bubble: pc_low=%0d nops=%0d stalled=%0d cnt=%0d, want 3/3/2/3",
                     lows, nops, sts, bc[1]);
        end
    endtask

    task automatic test_flush_abort();
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 11'h7F6);
        tick(1'b0, 1'b0, 1'b1, 11'h7F6);
        n_cmp++;
        if (pw_s[1] !== 1'b1 || co[1] !== 11'h000 || st[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_abort: pc_write=%b ctrl_out=%h stalled=%b, want 1/000/0", pw_s[1], co[1], st[1]);
        end
        tick(1'b0, 1'b0, 1'b0, 11'h7F6);
        n_cmp++;
        if (co[1] !== 11'h7F6 || bc[1] !== 32'd2) begin
            n_bad++;
            $display("FAIL flush_resume: ctrl_out=%h cnt=%0d, want 7f6/2", co[1], bc[1]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1'b0, 1'b1, 1'b1, 11'h7F6);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pw_s[i] !== 1'b1 || st[i] !== 1'b0 || co[i] !== 11'h000 || bc[i] !== 32'd1) begin
                n_bad++;
                $display("FAIL simultaneous inst%0d: pc_write=%b stalled=%b ctrl_out=%h cnt=%0d, want 1/0/000/1",
                         i, pw_s[i], st[i], co[i], bc[i]);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 11'h155);
        n_cmp++;
        if (co[1] !== 11'h155) begin
            n_bad++;
            $display("FAIL simultaneous_resume: ctrl_out=%h, want 155", co[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] c;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, 1'b0, 11'($urandom));
            n_cmp++;
            if (pw_s[0] !== 1'b0 || co[0] !== 11'h000 || ba[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: pc_write=%b ctrl_out=%h bub=%b, want 0/000/1", k, pw_s[0], co[0], ba[0]);
            end
        end
        c = 11'($urandom);
        tick(1'b0, 1'b0, 1'b0, c);
        n_cmp++;
        if (co[0] !== c || bc[0] !== 32'd4) begin
            n_bad++;
            $display("FAIL back_to_back_end: ctrl_out=%h cnt=%0d, want %h/4", co[0], bc[0], c);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, 1'b1, 11'h0AA);
            n_cmp++;
            if (bc[2] !== ((k < 3) ? k : 3)) begin
                n_bad++;
                $display("FAIL saturation[%0d]: cnt=%0d, want %0d", k, bc[2], (k < 3) ? k : 3);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 11'h0AA);
        n_cmp++;
        if (st[2] !== 1'b1 || bc[2] !== 32'd3) begin
            n_bad++;
            $display("FAIL sat_stall_entry: stalled=%b cnt=%0d, want 1/3", st[2], bc[2]);
        end
        tick(1'b1, 1'b0, 1'b0, 11'h0AA);
        n_cmp++;
        if (st[2] !== 1'b0 || co[2] !== 11'h000 || bc[2] !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_stall: stalled=%b ctrl_out=%h cnt=%0d, want 0/000/0", st[2], co[2], bc[2]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 15), 11'($urandom));
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (co[i] !== m_out[i] || ba[i] !== m_bub[i] || st[i] !== (m_pend[i] > 0) ||
                    bc[i] !== 32'(m_cnt[i]) || pw_s[i] !== pwe[i] || iw_s[i] !== pwe[i]) begin
                    n_bad++;
                    $display("FAIL random[%0d] inst%0d: out=%h bub=%b st=%b cnt=%0d pcw=%b ifw=%b, want %h/%b/%b/%0d/%b/%b",
                             k, i, co[i], ba[i], st[i], bc[i], pw_s[i], iw_s[i],
                             m_out[i], m_bub[i], (m_pend[i] > 0), m_cnt[i], pwe[i], pwe[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0; m_cnt[i] = 0; m_out[i] = '0; m_bub[i] = 1'b0;
        end
        test_reset();
        test_passthrough();
        test_single_bubble();
        test_multi_bubble();
        test_flush_abort();
        test_simultaneous();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
